mem_bus_arbiter: RTL and testbench

Shares the single external memory bus between the instruction-fetch requester (IF) and the load/store requester (MEM stage). It sits between the IF and MEM stages and the SRAM/Wishbone-style bus. Each access is granted, held and completed through a three-state FSM, and the pipeline is stalled while a request is outstanding. A bus timeout releases a hung access with an error pulse.

---
 rtl/mem_bus_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the IF and MEM stage requesters onto one Wishbone-style memory bus, with a wait timeout.
// Define MEM_ARB_RR_EN to use round-robin arbitration; the default is fixed MEM-over-IF priority.
module mem_bus_arbiter #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_rdata_o,
  output logic        if_ack_o,
  input  logic        mem_req_i,
  input  logic        mem_we_i,
  input  logic [31:0] mem_addr_i,
  input  logic [3:0]  mem_sel_i,
  input  logic [31:0] mem_wdata_i,
  output logic [31:0] mem_rdata_o,
  output logic        mem_ack_o,
  output logic        bus_cyc_o,
  output logic        bus_stb_o,
  output logic        bus_we_o,
  output logic [31:0] bus_adr_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_dat_o,
  input  logic [31:0] bus_dat_i,
  input  logic        bus_ack_i,
  output logic        stallreq_if_o,
  output logic        stallreq_mem_o,
  output logic        err_o
);

  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  typedef enum logic [1:0] {
    IDLE,
    IF_XFER,
    MEM_XFER
  } state_t;

  state_t      state_q, state_d;
  logic        cyc_q, cyc_d;
  logic        we_q, we_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic        if_ack_q, if_ack_d;
  logic        mem_ack_q, mem_ack_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] mem_rdata_q, mem_rdata_d;
  logic        err_q, err_d;
  logic [7:0]  wait_q, wait_d;
  logic        pick_mem;

`ifdef MEM_ARB_RR_EN
  logic last_mem_q, last_mem_d;
  // On contention the requester not served last wins; a lone request always wins.
  assign pick_mem = mem_req_i & (~if_req_i | ~last_mem_q);
`else
  assign pick_mem = mem_req_i;
`endif

  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    we_d        = we_q;
    sel_d       = sel_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    if_ack_d    = 1'b0;
    mem_ack_d   = 1'b0;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    err_d       = 1'b0;
    wait_d      = wait_q;
`ifdef MEM_ARB_RR_EN
    last_mem_d  = last_mem_q;
`endif
    case (state_q)
      IDLE: begin
        // No grant while any ack is out, so a request still held in its ack cycle is not served twice.
        if ((if_req_i || mem_req_i) && !if_ack_q && !mem_ack_q) begin
          cyc_d  = 1'b1;
          wait_d = '0;
          if (pick_mem) begin
            state_d = MEM_XFER;
            we_d    = mem_we_i;
            sel_d   = mem_sel_i;
            adr_d   = mem_addr_i;
            dat_d   = mem_wdata_i;
          end else begin
            state_d = IF_XFER;
            we_d    = 1'b0;
            sel_d   = '1;
            adr_d   = if_addr_i;
            dat_d   = '0;
          end
`ifdef MEM_ARB_RR_EN
          last_mem_d = pick_mem;
`endif
        end
      end
      IF_XFER, MEM_XFER: begin
        if (bus_ack_i) begin
          cyc_d   = 1'b0;
          state_d = IDLE;
          if (state_q == IF_XFER) begin
            if_ack_d   = 1'b1;
            if_rdata_d = bus_dat_i;
          end else begin
            mem_ack_d   = 1'b1;
            mem_rdata_d = bus_dat_i;
          end
        end else if (wait_q == MAX_WAIT_C) begin
          cyc_d   = 1'b0;
          state_d = IDLE;
          err_d   = 1'b1;
          if (state_q == IF_XFER) begin
            if_ack_d   = 1'b1;
            if_rdata_d = '0;
          end else begin
            mem_ack_d   = 1'b1;
            mem_rdata_d = '0;
          end
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= '0;
      adr_q       <= '0;
      dat_q       <= '0;
      if_ack_q    <= 1'b0;
      mem_ack_q   <= 1'b0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      err_q       <= 1'b0;
      wait_q      <= '0;
`ifdef MEM_ARB_RR_EN
      last_mem_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      sel_q       <= sel_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      if_ack_q    <= if_ack_d;
      mem_ack_q   <= mem_ack_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
      err_q       <= err_d;
      wait_q      <= wait_d;
`ifdef MEM_ARB_RR_EN
      last_mem_q  <= last_mem_d;
`endif
    end
  end

  assign bus_cyc_o      = cyc_q;
  assign bus_stb_o      = cyc_q;
  assign bus_we_o       = we_q;
  assign bus_sel_o      = sel_q;
  assign bus_adr_o      = adr_q;
  assign bus_dat_o      = dat_q;
  assign if_ack_o       = if_ack_q;
  assign mem_ack_o      = mem_ack_q;
  assign if_rdata_o     = if_rdata_q;
  assign mem_rdata_o    = mem_rdata_q;
  assign err_o          = err_q;
  assign stallreq_if_o  = if_req_i & ~if_ack_q;
  assign stallreq_mem_o = mem_req_i & ~mem_ack_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter (MAX_WAIT=4); expectations follow MEM_ARB_RR_EN.
module tb_mem_bus_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_i, mem_req_i, mem_we_i, bus_ack_i;
  logic [31:0] if_addr_i, mem_addr_i, mem_wdata_i, bus_dat_i;
  logic [3:0]  mem_sel_i;
  logic [31:0] if_rdata_o, mem_rdata_o, bus_adr_o, bus_dat_o;
  logic        if_ack_o, mem_ack_o, bus_cyc_o, bus_stb_o, bus_we_o, err_o;
  logic        stallreq_if_o, stallreq_mem_o;
  logic [3:0]  bus_sel_o;

  int n_assert = 0;
  int n_fail   = 0;

  mem_bus_arbiter #(.MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o), .if_ack_o(if_ack_o),
    .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i), .mem_sel_i(mem_sel_i),
    .mem_wdata_i(mem_wdata_i), .mem_rdata_o(mem_rdata_o), .mem_ack_o(mem_ack_o),
    .bus_cyc_o(bus_cyc_o), .bus_stb_o(bus_stb_o), .bus_we_o(bus_we_o), .bus_adr_o(bus_adr_o),
    .bus_sel_o(bus_sel_o), .bus_dat_o(bus_dat_o), .bus_dat_i(bus_dat_i), .bus_ack_i(bus_ack_i),
    .stallreq_if_o(stallreq_if_o), .stallreq_mem_o(stallreq_mem_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_idle_bus(input string tag);
    chk({tag, "_cyc"}, {31'd0, bus_cyc_o}, 32'd0);
    chk({tag, "_stb"}, {31'd0, bus_stb_o}, 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  logic [31:0] exp_adr;
  logic        exp_mem;

  initial begin
    if_req_i = 0; mem_req_i = 0; mem_we_i = 0; bus_ack_i = 0;
    if_addr_i = '0; mem_addr_i = '0; mem_wdata_i = '0; bus_dat_i = '0; mem_sel_i = '0;
    do_reset();

    // Reset state
    chk_idle_bus("rst");
    chk("rst_we", {31'd0, bus_we_o}, 32'd0);
    chk("rst_sel", {28'd0, bus_sel_o}, 32'd0);
    chk("rst_adr", bus_adr_o, 32'd0);
    chk("rst_dat", bus_dat_o, 32'd0);
    chk("rst_acks", {30'd0, if_ack_o, mem_ack_o}, 32'd0);
    chk("rst_rdata_if", if_rdata_o, 32'd0);
    chk("rst_rdata_mem", mem_rdata_o, 32'd0);
    chk("rst_err", {31'd0, err_o}, 32'd0);

    // Stray bus ack in IDLE is ignored
    bus_ack_i = 1; bus_dat_i = 32'hFFFF_FFFF;
    tick();
    chk_idle_bus("stray");
    chk("stray_acks", {30'd0, if_ack_o, mem_ack_o}, 32'd0);
    bus_ack_i = 0;

    // IF read, zero-wait slave
    if_req_i = 1; if_addr_i = 32'h0000_0100;
    #1 chk("if_stall_req", {31'd0, stallreq_if_o}, 32'd1);
    tick();
    chk("if_cyc", {31'd0, bus_cyc_o}, 32'd1);
    chk("if_stb", {31'd0, bus_stb_o}, 32'd1);
    chk("if_adr", bus_adr_o, 32'h0000_0100);
    chk("if_sel", {28'd0, bus_sel_o}, 32'hF);
    chk("if_we", {31'd0, bus_we_o}, 32'd0);
    chk("if_dat", bus_dat_o, 32'd0);
    bus_ack_i = 1; bus_dat_i = 32'hDEAD_BEEF;
    tick();
    chk("if_ack", {31'd0, if_ack_o}, 32'd1);
    chk("if_rdata", if_rdata_o, 32'hDEAD_BEEF);
    chk_idle_bus("if_done");
    chk("if_stall_ack", {31'd0, stallreq_if_o}, 32'd0);
    if_req_i = 0; bus_ack_i = 0;
    tick();
    chk("if_ack_pulse", {31'd0, if_ack_o}, 32'd0);
    chk("if_rdata_hold", if_rdata_o, 32'hDEAD_BEEF);

    // MEM write, slave waits 3 cycles
    mem_req_i = 1; mem_we_i = 1; mem_addr_i = 32'h0000_0200; mem_sel_i = 4'b0011;
    mem_wdata_i = 32'h1234_5678;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("mw_cyc", {31'd0, bus_cyc_o}, 32'd1);
      chk("mw_we", {31'd0, bus_we_o}, 32'd1);
      chk("mw_adr", bus_adr_o, 32'h0000_0200);
      chk("mw_sel", {28'd0, bus_sel_o}, 32'h3);
      chk("mw_dat", bus_dat_o, 32'h1234_5678);
      chk("mw_ack_low", {31'd0, mem_ack_o}, 32'd0);
      chk("mw_stall", {31'd0, stallreq_mem_o}, 32'd1);
    end
    bus_ack_i = 1; bus_dat_i = 32'hCAFE_F00D;
    tick();
    chk("mw_ack", {31'd0, mem_ack_o}, 32'd1);
    chk("mw_stall_ack", {31'd0, stallreq_mem_o}, 32'd0);
    chk("mw_rdata", mem_rdata_o, 32'hCAFE_F00D);
    chk_idle_bus("mw_done");
    mem_req_i = 0; mem_we_i = 0; bus_ack_i = 0;
    tick();
    chk("mw_ack_pulse", {31'd0, mem_ack_o}, 32'd0);

    // Both requests held; reset first so last-grant starts at IF
    do_reset();
    mem_req_i = 1; mem_addr_i = 32'h0000_0300; mem_sel_i = 4'hF;
    if_req_i = 1; if_addr_i = 32'h0000_0400;
    bus_ack_i = 1; bus_dat_i = 32'h1111_0000;
    for (int k = 0; k < 3; k++) begin
`ifdef MEM_ARB_RR_EN
      exp_mem = (k != 1);
`else
      exp_mem = 1'b1;
`endif
      exp_adr = exp_mem ? 32'h0000_0300 : 32'h0000_0400;
      tick();
      chk("arb_cyc", {31'd0, bus_cyc_o}, 32'd1);
      chk("arb_adr", bus_adr_o, exp_adr);
      tick();
      chk("arb_acks", {30'd0, if_ack_o, mem_ack_o}, {30'd0, ~exp_mem, exp_mem});
      if (k == 2) mem_req_i = 0;
      tick();
      chk_idle_bus("arb_gap");
    end
    tick();
    chk("arb_if_cyc", {31'd0, bus_cyc_o}, 32'd1);
    chk("arb_if_adr", bus_adr_o, 32'h0000_0400);
    tick();
    chk("arb_if_ack", {31'd0, if_ack_o}, 32'd1);
    chk("arb_if_rdata", if_rdata_o, 32'h1111_0000);
    if_req_i = 0; bus_ack_i = 0;
    tick();

    // Timeout with MAX_WAIT=4
    if_req_i = 1; if_addr_i = 32'h0000_0500;
    tick();
    chk("to_cyc", {31'd0, bus_cyc_o}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("to_wait_cyc", {31'd0, bus_cyc_o}, 32'd1);
      chk("to_wait_ack_err", {30'd0, if_ack_o, err_o}, 32'd0);
    end
    tick();
    chk("to_cyc_drop", {31'd0, bus_cyc_o}, 32'd0);
    chk("to_err", {31'd0, err_o}, 32'd1);
    chk("to_ack", {31'd0, if_ack_o}, 32'd1);
    chk("to_rdata", if_rdata_o, 32'd0);
    if_req_i = 0;
    tick();
    chk("to_pulse", {30'd0, if_ack_o, err_o}, 32'd0);
    chk_idle_bus("to_idle");

    // Reset during MEM transfer, then normal completion
    mem_req_i = 1; mem_we_i = 0; mem_addr_i = 32'h0000_0600;
    tick();
    chk("rx_cyc", {31'd0, bus_cyc_o}, 32'd1);
    tick();
    rst = 1'b1;
    tick();
    chk_idle_bus("rx_rst");
    chk("rx_ack_err", {29'd0, if_ack_o, mem_ack_o, err_o}, 32'd0);
    chk("rx_rdata", mem_rdata_o, 32'd0);
    rst = 1'b0;
    tick();
    chk("rx_regrant", {31'd0, bus_cyc_o}, 32'd1);
    chk("rx_adr", bus_adr_o, 32'h0000_0600);
    bus_ack_i = 1; bus_dat_i = 32'h0BAD_F00D;
    tick();
    chk("rx_ack", {31'd0, mem_ack_o}, 32'd1);
    chk("rx_rdata2", mem_rdata_o, 32'h0BAD_F00D);
    chk("rx_err", {31'd0, err_o}, 32'd0);
    mem_req_i = 0; bus_ack_i = 0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
